seq_multiplier_32bit: RTL
=========================

# seq_multiplier_32bit

- Sequential radix-2 shift-add multiplier, the inverse-direction companion of the 32-bit divider in the ALU datapath.
- Takes two WIDTH-bit operands through a start/done handshake and returns the full 2*WIDTH-bit product after a fixed latency.
- Supports unsigned and two's-complement signed operation, selected per operation.
- Used by the ALU multiply path and by the divider bench to reconstruct dividend = quotient*divisor + remainder.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits; WIDTH >= 4.
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  request; accepted only when BUSY=0.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- OP1  input  WIDTH  multiplicand; sampled on the accepting edge.
- OP2  input  WIDTH  multiplier; sampled on the accepting edge.
- BUSY  output  1  high from the accepting edge until the DONE edge.
- DONE  output  1  one-cycle pulse; RESULT valid.
- RESULT  output  2*WIDTH  product; held until the next DONE.

## Operation
- FSM states:
  - IDLE: on START=1, capture |OP1|, |OP2|, neg = SIGNED & (OP1[MSB] ^ OP2[MSB]); clear accumulator; count = 0; go to CALC.
  - CALC: one iteration per cycle. If multiplier LSB = 1, add the multiplicand to the accumulator upper half, keeping the carry. Shift the {carry, accumulator, multiplier} right by 1. count++. After iteration WIDTH-1, go to SIGN.
  - SIGN: RESULT <= neg ? two's-complement of the accumulator : accumulator. Pulse DONE; go to IDLE.
- Magnitude rule:
  - In signed mode, a negative operand's magnitude is its two's complement taken as WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - In unsigned mode, operands are used as-is and neg = 0.
- Arithmetic is exact. The full 2*WIDTH-bit product is always representable, including (-2^31)*(-2^31) = 2^62, so there is no overflow output.
- START while BUSY=1 is ignored: no queueing, and operands are not resampled.
- SIGNED, OP1 and OP2 are don't-care except on the accepting edge.
- Zero operand: no early termination; latency stays fixed.

## Timing
- Reset values: BUSY=0, DONE=0, RESULT=0, state IDLE, count=0.
- RST=1 mid-operation:
  - aborts at that edge;
  - next cycle is IDLE with BUSY=0, DONE=0, RESULT=0;
  - no DONE is produced for the aborted operation.
- RST has priority over START on the same edge.
- Latency: START sampled high at edge k with BUSY=0:
  - BUSY=1 after edge k;
  - after edge k+WIDTH, state is SIGN;
  - after edge k+WIDTH+1, DONE=1, BUSY=0 and RESULT is updated.
  - DONE is visible WIDTH+1 cycles after acceptance (33 for WIDTH=32).
- DONE is high for exactly one cycle.
- START high in the cycle DONE is high (BUSY=0) is accepted at the next edge. Back-to-back throughput is therefore one operation per WIDTH+2 cycles.
- RESULT changes only on the DONE edge or on reset.

## Test plan
- Reset: assert RST for 2 cycles with START=1 -> BUSY=0, DONE=0, RESULT=0; no operation starts.
- Unsigned basic: OP1=0x0000_0007, OP2=0x0000_0006, SIGNED=0 -> DONE exactly 33 cycles after acceptance, RESULT=0x0000_0000_0000_002A, BUSY high for 33 cycles.
- Unsigned max: OP1=OP2=0xFFFF_FFFF, SIGNED=0 -> RESULT=0xFFFF_FFFE_0000_0001.
- Signed corners:
  - OP1=0xFFFF_FFFD (-3), OP2=0x0000_0005, SIGNED=1 -> RESULT=0xFFFF_FFFF_FFFF_FFF1 (-15).
  - OP1=OP2=0x8000_0000, SIGNED=1 -> RESULT=0x4000_0000_0000_0000.
- Handshake:
  - START pulsed again at cycle 10 of busy with OP1=OP2=0x1 -> ignored; the first result still completes.
  - START held high through DONE with OP1=2, OP2=3 -> next operation is accepted at that edge; second DONE 33 cycles later with RESULT=6.
- Reset mid-operation: start 0x1234*0x10, assert RST at cycle 15 -> no DONE, RESULT=0. A new start of 0x1234*0x10 then gives RESULT=0x12340.

Source files
------------

// File: rtl/seq_multiplier_32bit.sv
// Radix-2 shift-add multiplier, unsigned or two's-complement per operation.
// Latency WIDTH+1 cycles from acceptance to DONE; START is ignored while BUSY.
module seq_multiplier_32bit #(
   parameter int WIDTH = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               SIGNED,
   input  logic [WIDTH-1:0]   OP1,
   input  logic [WIDTH-1:0]   OP2,
   output logic               BUSY,
   output logic               DONE,
   output logic [2*WIDTH-1:0] RESULT
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   op1_mag, op2_mag, addend;
   logic [WIDTH:0]     sum;

   always_comb begin
      // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude
      op1_mag = (SIGNED && OP1[WIDTH-1]) ? -OP1 : OP1;
      op2_mag = (SIGNED && OP2[WIDTH-1]) ? -OP2 : OP2;
      addend  = acc_q[0] ? mcand_q : '0;
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      done_d   = 1'b0;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (START) begin
               mcand_d = op1_mag;
               acc_d   = {{WIDTH{1'b0}}, op2_mag};
               neg_d   = SIGNED & (OP1[WIDTH-1] ^ OP2[WIDTH-1]);
               count_d = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // low half holds the remaining multiplier bits, consumed from the LSB
            acc_d   = {sum, acc_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            result_d = neg_q ? -acc_q : acc_q;
            done_d   = 1'b1;
            count_d  = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign BUSY   = (state_q != IDLE);
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule
